store_dealer: RTL and testbench
===============================

Name: store_dealer

Overview:
- Store-side counterpart of the load data path. Takes a store (opcode, effective address, rt register data) from the MEM stage and formats it into a word-aligned address, a 4-bit byte-enable and lane-shifted write data for sb/sh/sw/swl/swr. Byte order is little-endian.
- Queues formatted stores in a small FIFO that drains to the data-memory write port through a valid/ready handshake.
- Raises an address-error-on-store (AdES) exception for misaligned sh/sw.

Parameters:
- DEPTH, 2, number of store-buffer entries; must be a power of two and at least 2.
- PTR_W, 1, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  store request from the MEM stage is valid.
- in_ready  out  1  request is accepted this cycle.
- in_opcode  in  6  instruction opcode.
- in_addr  in  32  effective (byte) address.
- in_regdata  in  32  rt register value.
- mem_valid  out  1  buffer head holds a write for memory.
- mem_ready  in  1  memory accepts the head this cycle.
- mem_addr  out  32  word address of the head; bits [1:0] are always 0.
- mem_wen  out  4  byte enables of the head.
- mem_wdata  out  32  write data of the head.
- ades  out  1  one-cycle AdES exception pulse.
- ades_badvaddr  out  32  faulting address; held until the next ades pulse.
- buf_count  out  PTR_W+1  number of occupied entries.
- buf_empty  out  1  high when buf_count is 0; used for sync/uncached ordering.

Behaviour:
- Decode uses ea = in_addr[1:0] and rt = in_regdata. A store is an opcode of 40, 41, 42, 43 or 46.
- sb (opcode 40):
  - wen = 4'b0001 << ea
  - wdata = {24'b0, rt[7:0]} << (8*ea)
- sh (opcode 41):
  - ea = 0: wen = 0011, wdata = {16'b0, rt[15:0]}
  - ea = 2: wen = 1100, wdata = {rt[15:0], 16'b0}
  - ea = 1 or 3: misaligned.
- sw (opcode 43):
  - ea = 0: wen = 1111, wdata = rt
  - any other ea: misaligned.
- swl (opcode 42):
  - ea = 0: wen = 0001, wdata = {24'b0, rt[31:24]}
  - ea = 1: wen = 0011, wdata = {16'b0, rt[31:16]}
  - ea = 2: wen = 0111, wdata = {8'b0, rt[31:8]}
  - ea = 3: wen = 1111, wdata = rt
- swr (opcode 46):
  - ea = 0: wen = 1111, wdata = rt
  - ea = 1: wen = 1110, wdata = {rt[23:0], 8'b0}
  - ea = 2: wen = 1100, wdata = {rt[15:0], 16'b0}
  - ea = 3: wen = 1000, wdata = {rt[7:0], 24'b0}
- Byte lanes with a wen bit of 0 carry 0 in wdata.
- Stored entry address is {in_addr[31:2], 2'b00}.
- Acceptance:
  - in_ready = !full, where full means buf_count == DEPTH.
  - in_ready is independent of mem_ready: there is no fall-through when full.
- Enqueue happens when in_valid and in_ready are both high and the opcode is a well-aligned store.
- Non-store opcode with in_valid high: accepted and dropped; no entry, no exception.
- Misaligned sh/sw (when accepted):
  - No entry is written.
  - ades goes high on the next cycle for exactly one cycle.
  - ades_badvaddr takes in_addr on the same edge.
- Dequeue happens when mem_valid and mem_ready are both high. The read pointer advances and the write pointer wraps modulo DEPTH.
- Simultaneous enqueue and dequeue (not full): buf_count is unchanged and both pointers advance.
- Latency: an entry enqueued at edge N is visible on mem_valid/mem_addr/mem_wen/mem_wdata from edge N onward, i.e. the cycle after acceptance. There is no combinational input-to-memory path.
- mem_valid = !buf_empty.
- When the buffer is empty, mem_addr, mem_wen and mem_wdata are forced to 0.
- Head outputs are stable while mem_valid is high and mem_ready is low. Entries are presented and drained in strict FIFO order.
- Reset (rst high at an edge):
  - Pointers and buf_count go to 0, buf_empty goes to 1.
  - mem_valid, ades and ades_badvaddr go to 0.
  - Entries pending at reset are discarded and in_valid is ignored that cycle.
  - in_ready is 1 from the first cycle after reset.

Test Plan:
- sb, addr 0x1003, rt 0x11223344, mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x1000, mem_wen=1000, mem_wdata=0x44000000.
- swl, addr 0x2001, rt 0xAABBCCDD -> mem_wen=0011, mem_wdata=0x0000AABB. Then swr at addr 0x2001 -> mem_wen=1110, mem_wdata=0xBBCCDD00.
- sw at 0x3002 -> no entry, buf_count stays 0, ades pulses exactly 1 cycle, ades_badvaddr=0x3002. sh at 0x3002 with rt 0x1234 -> mem_wen=1100, mem_wdata=0x12340000.
- mem_ready=0, three sw pushes (DEPTH=2) -> in_ready drops after the 2nd, buf_count=2. Raise mem_ready -> entries drain in order. A push in the cycle buf_count=1 with a pop leaves the count at 1.
- Random opcodes/addresses/rt, random mem_ready, 10k cycles -> drained stream matches a reference queue; no loss or duplication; head stable while stalled.
- rst asserted with 2 entries pending and in_valid=1 -> next cycle buf_count=0, mem_valid=0, ades=0, in_ready=1.

Source files
------------

// File: rtl/store_dealer.sv
// store_dealer
// Formats sb/sh/sw/swl/swr stores into a word address, a byte-enable mask and
// lane-shifted write data (little-endian). Formatted stores wait in a small
// FIFO that drains to the data-memory write port over a valid/ready handshake.
// A misaligned sh/sw is dropped and raises a one-cycle AdES pulse.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        store request handshake from the MEM stage
//   in_opcode/in_addr        opcode and effective byte address
//   in_regdata               rt register value
//   mem_valid/mem_ready      head-of-buffer handshake to data memory
//   mem_addr/mem_wen/mem_wdata  head entry (all zero while the buffer is empty)
//   ades, ades_badvaddr      AdES pulse and the faulting address (held)
//   buf_count, buf_empty     buffer occupancy

module store_dealer #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_regdata,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_wen,
    output logic [31:0]      mem_wdata,
    output logic             ades,
    output logic [31:0]      ades_badvaddr,
    output logic [PTR_W:0]   buf_count,
    output logic             buf_empty
);

    localparam logic [5:0] OP_SB  = 6'd40;
    localparam logic [5:0] OP_SH  = 6'd41;
    localparam logic [5:0] OP_SWL = 6'd42;
    localparam logic [5:0] OP_SW  = 6'd43;
    localparam logic [5:0] OP_SWR = 6'd46;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [29:0]      addr_mem  [DEPTH];
    logic [3:0]       wen_mem   [DEPTH];
    logic [31:0]      wdata_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ades_q, ades_d;
    logic [31:0]      badvaddr_q, badvaddr_d;

    logic [1:0]       ea;
    logic [31:0]      rt;
    logic             is_store;
    logic             misaligned;
    logic [3:0]       fmt_wen;
    logic [31:0]      fmt_wdata;
    logic             accept;
    logic             enq;
    logic             deq;

    assign ea = in_addr[1:0];
    assign rt = in_regdata;

    // Store formatting; lanes not enabled are left at zero.
    always_comb begin
        is_store   = 1'b1;
        misaligned = 1'b0;
        fmt_wen    = 4'b0000;
        fmt_wdata  = 32'h0;
        case (in_opcode)
            OP_SB: begin
                fmt_wen   = 4'b0001 << ea;
                fmt_wdata = {24'h0, rt[7:0]} << {ea, 3'b000};
            end
            OP_SH: begin
                case (ea)
                    2'd0: begin
                        fmt_wen   = 4'b0011;
                        fmt_wdata = {16'h0, rt[15:0]};
                    end
                    2'd2: begin
                        fmt_wen   = 4'b1100;
                        fmt_wdata = {rt[15:0], 16'h0};
                    end
                    default: misaligned = 1'b1;
                endcase
            end
            OP_SW: begin
                if (ea == 2'd0) begin
                    fmt_wen   = 4'b1111;
                    fmt_wdata = rt;
                end else begin
                    misaligned = 1'b1;
                end
            end
            OP_SWL: begin
                case (ea)
                    2'd0: begin fmt_wen = 4'b0001; fmt_wdata = {24'h0, rt[31:24]}; end
                    2'd1: begin fmt_wen = 4'b0011; fmt_wdata = {16'h0, rt[31:16]}; end
                    2'd2: begin fmt_wen = 4'b0111; fmt_wdata = {8'h0, rt[31:8]};   end
                    default: begin fmt_wen = 4'b1111; fmt_wdata = rt;             end
                endcase
            end
            OP_SWR: begin
                case (ea)
                    2'd0: begin fmt_wen = 4'b1111; fmt_wdata = rt;                 end
                    2'd1: begin fmt_wen = 4'b1110; fmt_wdata = {rt[23:0], 8'h0};   end
                    2'd2: begin fmt_wen = 4'b1100; fmt_wdata = {rt[15:0], 16'h0};  end
                    default: begin fmt_wen = 4'b1000; fmt_wdata = {rt[7:0], 24'h0}; end
                endcase
            end
            default: is_store = 1'b0;
        endcase
    end

    // in_ready depends only on occupancy, so a full buffer never falls through.
    assign in_ready = (count_q != FULL_CNT);
    assign accept   = in_valid && in_ready;
    assign enq      = accept && is_store && !misaligned;
    assign deq      = mem_valid && mem_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ades_d     = accept && misaligned;
        badvaddr_d = badvaddr_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        if (accept && misaligned) begin
            badvaddr_d = in_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ades_q     <= 1'b0;
            badvaddr_q <= 32'h0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ades_q     <= ades_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            addr_mem[wr_ptr_q]  <= in_addr[31:2];
            wen_mem[wr_ptr_q]   <= fmt_wen;
            wdata_mem[wr_ptr_q] <= fmt_wdata;
        end
    end

    assign buf_count     = count_q;
    assign buf_empty     = (count_q == '0);
    assign mem_valid     = !buf_empty;
    assign mem_addr      = buf_empty ? 32'h0 : {addr_mem[rd_ptr_q], 2'b00};
    assign mem_wen       = buf_empty ? 4'h0  : wen_mem[rd_ptr_q];
    assign mem_wdata     = buf_empty ? 32'h0 : wdata_mem[rd_ptr_q];
    assign ades          = ades_q;
    assign ades_badvaddr = badvaddr_q;

endmodule

// File: tb/tb_store_dealer.sv
// Directed bench for store_dealer: formatting of every store flavour, AdES
// handling, full/backpressure behaviour, simultaneous push/pop and reset.

module tb_store_dealer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [31:0] in_addr;
    logic [31:0] in_regdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic        ades;
    logic [31:0] ades_badvaddr;
    logic [1:0]  buf_count;
    logic        buf_empty;

    int n_checks;
    int n_errors;

    store_dealer #(.DEPTH(2), .PTR_W(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_addr       (in_addr),
        .in_regdata    (in_regdata),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .ades          (ades),
        .ades_badvaddr (ades_badvaddr),
        .buf_count     (buf_count),
        .buf_empty     (buf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        in_valid   = v;
        in_opcode  = op;
        in_addr    = a;
        in_regdata = d;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wen;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[9];

    initial begin
        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{6'd40, 32'h0000_0101, 32'hA1B2_C3D4, 32'h0000_0100, 4'b0010, 32'h0000_D400};
        vecs[1] = '{6'd41, 32'h0000_0200, 32'hFFFF_5678, 32'h0000_0200, 4'b0011, 32'h0000_5678};
        vecs[2] = '{6'd43, 32'h0000_0304, 32'hDEAD_BEEF, 32'h0000_0304, 4'b1111, 32'hDEAD_BEEF};
        vecs[3] = '{6'd42, 32'h0000_0403, 32'h0102_0304, 32'h0000_0400, 4'b1111, 32'h0102_0304};
        vecs[4] = '{6'd42, 32'h0000_0402, 32'h0102_0304, 32'h0000_0400, 4'b0111, 32'h0001_0203};
        vecs[5] = '{6'd42, 32'h0000_0400, 32'h0102_0304, 32'h0000_0400, 4'b0001, 32'h0000_0001};
        vecs[6] = '{6'd46, 32'h0000_0503, 32'h0102_0304, 32'h0000_0500, 4'b1000, 32'h0400_0000};
        vecs[7] = '{6'd46, 32'h0000_0502, 32'h0102_0304, 32'h0000_0500, 4'b1100, 32'h0304_0000};
        vecs[8] = '{6'd40, 32'h0000_0602, 32'h0000_00AB, 32'h0000_0600, 4'b0100, 32'h00AB_0000};

        rst       = 1'b1;
        mem_ready = 1'b0;
        drive(1'b0, 6'd0, 32'h0, 32'h0);
        step();
        step();
        rst = 1'b0;
        check("rst_count", 32'(buf_count), 32'd0);
        check("rst_empty", 32'(buf_empty), 32'd1);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_ades", 32'(ades), 32'd0);
        check("rst_badvaddr", ades_badvaddr, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // sb at byte 3
        mem_ready = 1'b1;
        drive(1'b1, 6'd40, 32'h0000_1003, 32'h1122_3344);
        step();
        drive(1'b0, 6'd0, 32'h0, 32'h0);
        check("sb_valid", 32'(mem_valid), 32'd1);
        check("sb_addr", mem_addr, 32'h0000_1000);
        check("sb_wen", 32'(mem_wen), 32'h8);
        check("sb_wdata", mem_wdata, 32'h4400_0000);
        step();
        check("sb_drained", 32'(mem_valid), 32'd0);
        check("empty_forced_addr", mem_addr, 32'h0);

        // swl then swr at 0x2001; swr pushed in the same cycle the swl pops
        mem_ready = 1'b0;
        drive(1'b1, 6'd42, 32'h0000_2001, 32'hAABB_CCDD);
        step();
        check("swl_wen", 32'(mem_wen), 32'h3);
        check("swl_wdata", mem_wdata, 32'h0000_AABB);
        mem_ready = 1'b1;
        drive(1'b1, 6'd46, 32'h0000_2001, 32'hAABB_CCDD);
        step();
        drive(1'b0, 6'd0, 32'h0, 32'h0);
        check("swr_count", 32'(buf_count), 32'd1);
        check("swr_wen", 32'(mem_wen), 32'hE);
        check("swr_wdata", mem_wdata, 32'hBBCC_DD00);
        step();
        check("swr_drained", 32'(buf_count), 32'd0);

        // misaligned sw
        drive(1'b1, 6'd43, 32'h0000_3002, 32'h5555_5555);
        step();
        drive(1'b0, 6'd0, 32'h0, 32'h0);
        check("ades_pulse", 32'(ades), 32'd1);
        check("ades_badvaddr", ades_badvaddr, 32'h0000_3002);
        check("ades_no_entry", 32'(buf_count), 32'd0);
        step();
        check("ades_one_cycle", 32'(ades), 32'd0);
        check("ades_badvaddr_held", ades_badvaddr, 32'h0000_3002);

        // aligned sh at ea 2
        mem_ready = 1'b0;
        drive(1'b1, 6'd41, 32'h0000_3002, 32'h0000_1234);
        step();
        drive(1'b0, 6'd0, 32'h0, 32'h0);
        check("sh2_ades", 32'(ades), 32'd0);
        check("sh2_wen", 32'(mem_wen), 32'hC);
        check("sh2_wdata", mem_wdata, 32'h1234_0000);
        mem_ready = 1'b1;
        step();
        check("sh2_drained", 32'(buf_count), 32'd0);

        // misaligned sh at ea 1, then a non-store opcode
        drive(1'b1, 6'd41, 32'h0000_7001, 32'h0);
        step();
        drive(1'b1, 6'd35, 32'h0000_8002, 32'h1);
        check("sh1_ades", 32'(ades), 32'd1);
        check("sh1_badvaddr", ades_badvaddr, 32'h0000_7001);
        step();
        drive(1'b0, 6'd0, 32'h0, 32'h0);
        check("nonstore_ades", 32'(ades), 32'd0);
        check("nonstore_count", 32'(buf_count), 32'd0);
        check("nonstore_badvaddr", ades_badvaddr, 32'h0000_7001);

        // formatting table
        foreach (vecs[i]) begin
            mem_ready = 1'b0;
            drive(1'b1, vecs[i].op, vecs[i].addr, vecs[i].rt);
            step();
            drive(1'b0, 6'd0, 32'h0, 32'h0);
            check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_wen", i), 32'(mem_wen), 32'(vecs[i].exp_wen));
            check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
            mem_ready = 1'b1;
            step();
            check($sformatf("vec%0d_drained", i), 32'(buf_count), 32'd0);
        end

        // fill under backpressure
        mem_ready = 1'b0;
        drive(1'b1, 6'd43, 32'h0000_0010, 32'h1);
        step();
        check("fill1_count", 32'(buf_count), 32'd1);
        check("fill1_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 6'd43, 32'h0000_0014, 32'h2);
        step();
        check("fill2_count", 32'(buf_count), 32'd2);
        check("fill2_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 6'd43, 32'h0000_0018, 32'h3);
        step();
        check("full_count", 32'(buf_count), 32'd2);
        check("full_head_addr", mem_addr, 32'h0000_0010);
        check("full_head_data", mem_wdata, 32'h1);
        mem_ready = 1'b1;
        drive(1'b0, 6'd0, 32'h0, 32'h0);
        step();
        check("drain1_count", 32'(buf_count), 32'd1);
        check("drain1_addr", mem_addr, 32'h0000_0014);
        check("drain1_data", mem_wdata, 32'h2);
        drive(1'b1, 6'd43, 32'h0000_001C, 32'h4);
        step();
        drive(1'b0, 6'd0, 32'h0, 32'h0);
        check("pushpop_count", 32'(buf_count), 32'd1);
        check("pushpop_addr", mem_addr, 32'h0000_001C);
        check("pushpop_data", mem_wdata, 32'h4);
        step();
        check("drain2_count", 32'(buf_count), 32'd0);

        // reset with two entries pending and a misaligned request presented
        mem_ready = 1'b0;
        drive(1'b1, 6'd43, 32'h0000_0020, 32'h5);
        step();
        drive(1'b1, 6'd43, 32'h0000_0024, 32'h6);
        step();
        check("prerst_count", 32'(buf_count), 32'd2);
        rst = 1'b1;
        drive(1'b1, 6'd43, 32'h0000_3002, 32'h7);
        step();
        rst = 1'b0;
        drive(1'b0, 6'd0, 32'h0, 32'h0);
        check("rst2_count", 32'(buf_count), 32'd0);
        check("rst2_mem_valid", 32'(mem_valid), 32'd0);
        check("rst2_ades", 32'(ades), 32'd0);
        check("rst2_badvaddr", ades_badvaddr, 32'h0);
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        check("rst2_empty", 32'(buf_empty), 32'd1);
        step();
        check("rst2_stay_empty", 32'(buf_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
